rv32_multicycle_ctrl: RTL
=========================

// Module: rv32_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the RV32I core: sequences fetch/decode/execute/mem/writeback over the shared
//  datapath (PC, IR, regfile, ALU, unified memory port). Drives all mux selects and write enables; waits on
//  memory handshake; traps on illegal opcode or memory timeout. Sits beside the datapath inside main.
// PARAMETERS
//  WAIT_MAX  16  max consecutive cycles mem_ready may stay low in a memory state before bus-error trap
//  CNT_W     32  width of performance counters (optional feature)
// PORTS
//  CLK           in   1   single clock, rising edge
//  RST           in   1   synchronous, active-high reset
//  opcode        in   7   IR[6:0]
//  funct3        in   3   IR[14:12]
//  funct7_5      in   1   IR[30]
//  branch_taken  in   1   datapath comparator result for current funct3
//  mem_ready     in   1   memory completes request this cycle
//  pc_write      out  1   PC <= pc_next
//  ir_write      out  1   IR <= mem rdata, OldPC <= PC
//  addr_src      out  1   0=PC, 1=ALUOut as memory address
//  mem_req       out  1   memory request valid
//  mem_we        out  1   memory write (with mem_req)
//  reg_write     out  1   regfile write rd
//  alu_src_a     out  2   00 PC, 01 OldPC, 10 rs1, 11 zero
//  alu_src_b     out  2   00 rs2, 01 imm, 10 const 4
//  alu_op        out  2   00 add, 01 sub, 10 decode funct3/funct7_5
//  result_src    out  2   00 ALUOut reg, 01 mem rdata, 10 ALU result direct
//  illegal_instr out  1   sticky: unknown opcode trapped
//  bus_error     out  1   sticky: mem_ready timeout trapped
//  instret       out  CNT_W  retired instructions (optional)
//  cycles        out  CNT_W  cycles since reset (optional)
// BEHAVIOUR
//  Reset: state=FETCH; every output 0; wait counter 0; sticky flags cleared. RST mid-instruction aborts it,
//   no write enable asserts in the reset cycle.
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, TRAP.
//  FETCH: mem_req=1, addr_src=0, alu PC+4 (a=00,b=10,op=00); ir_write=pc_write=1 only in cycle mem_ready=1,
//   then ->DECODE; else stay.
//  DECODE: a=01,b=01,op=00 (branch target into ALUOut). Opcode 0000011/0100011->MEMADR, 0110011->EXECR,
//   0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->UPPER, other->TRAP.
//  MEMADR: a=10,b=01; ->MEMRD (load) or MEMWR (store). MEMRD: mem_req=1,addr_src=1; on ready ->MEMWB.
//  MEMWB: result_src=01, reg_write=1 ->FETCH. MEMWR: mem_req=mem_we=1,addr_src=1; on ready ->FETCH.
//  EXECR: a=10,b=00,op=10 ->ALUWB. EXECI: a=10,b=01,op=10 ->ALUWB. ALUWB: result_src=00, reg_write=1 ->FETCH.
//  BRANCH: a=10,b=00,op=01, result_src=00; pc_write=branch_taken (only Mealy output) ->FETCH.
//  JAL: a=01,b=10 (rd=OldPC+4), result_src=10, reg_write=1, pc_write=1 from ALUOut ->FETCH.
//  JALR: pass 1 computes rs1+imm into ALUOut; pass 2 as JAL. UPPER: a=11(LUI)/01(AUIPC), b=01 ->ALUWB.
//  Latency (zero wait): R/I/upper 4, load 5, store 4, branch 3, JAL 3, JALR 4 cycles incl. FETCH.
//  Wait counter: counts consecutive mem_req & !mem_ready; reset on ready or state change; reaching WAIT_MAX
//   ->TRAP with bus_error=1, no write enables in that cycle.
//  TRAP: all enables 0, holds until RST; illegal_instr or bus_error stays 1.
// CONFIGURATION
//  RV32_CTRL_PERF_EN defined: cycles increments each non-reset cycle; instret increments on every transition
//   into FETCH from a completing state; both wrap modulo 2^CNT_W, frozen in TRAP.
//  Not defined: counters not built; instret and cycles tied to 0.
// STRUCTURE
//  Package rv32_ctrl_pkg: state encoding, opcode constants, alu_src_a/b, alu_op, result_src encodings.
//  Sub-module rv32_wait_timer: wait counter + timeout compare, shared by FETCH/MEMRD/MEMWR.
// TESTING
//  add x3,x1,x2 (0x002081B3), ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4 only.
//  lw with mem_ready low 3 cycles in MEMRD -> 8 cycles total, reg_write at MEMWB, bus_error=0.
//  beq taken/not taken -> pc_write=1/0 in BRANCH cycle, back in FETCH after 3 cycles.
//  opcode 0x7F -> TRAP after DECODE, illegal_instr=1 held until RST, no enables asserted.
//  mem_ready held low 16 cycles in FETCH -> TRAP, bus_error=1; RST asserted in MEMWR -> FETCH, all outputs 0.
//  PERF_EN: 10 add instrs -> instret=10, cycles=40; build without macro -> both read 0.

Source files
------------

// File: rtl/rv32_multicycle_ctrl_pkg.sv
// Shared encodings and per-state control words for the RV32I multicycle controller.
// Latency: none (package of types, constants and a pure decode function).
// Backpressure: n/a.
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11} alu_a_e;
    typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_b_e;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} res_src_e;

    // Moore part of the control outputs; ready/branch dependent enables are added in the top.
    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     addr_src;
        logic     reg_write;
        logic     pc_write;
        alu_a_e   alu_src_a;
        alu_b_e   alu_src_b;
        alu_op_e  alu_op;
        res_src_e result_src;
    } ctl_t;

    // Control word held while the FSM sits in state s (opcode only matters for UPPER).
    function automatic ctl_t ctl_for(state_e s, logic [6:0] opcode);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_a = A_PC; c.alu_src_b = B_FOUR; end
            S_DECODE: begin c.alu_src_a = A_OLDPC; c.alu_src_b = B_IMM; end
            S_MEMADR: begin c.alu_src_a = A_RS1; c.alu_src_b = B_IMM; end
            S_MEMRD:  begin c.mem_req = 1'b1; c.addr_src = 1'b1; end
            S_MEMWB:  begin c.result_src = RES_MEM; c.reg_write = 1'b1; end
            S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr_src = 1'b1; end
            S_EXECR:  begin c.alu_src_a = A_RS1; c.alu_src_b = B_RS2; c.alu_op = ALU_FUNCT; end
            S_EXECI:  begin c.alu_src_a = A_RS1; c.alu_src_b = B_IMM; c.alu_op = ALU_FUNCT; end
            S_ALUWB:  begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
            S_BRANCH: begin c.alu_src_a = A_RS1; c.alu_src_b = B_RS2; c.alu_op = ALU_SUB; end
            S_JAL:    begin
                c.alu_src_a = A_OLDPC; c.alu_src_b = B_FOUR; c.result_src = RES_ALU;
                c.reg_write = 1'b1; c.pc_write = 1'b1;
            end
            S_JALR:   begin c.alu_src_a = A_RS1; c.alu_src_b = B_IMM; end
            S_UPPER:  begin
                c.alu_src_a = (opcode == OP_LUI) ? A_ZERO : A_OLDPC;
                c.alu_src_b = B_IMM;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Bundle between the multicycle controller (master) and the datapath (slave).
// Latency: none (wires only).
// Backpressure: memory stalls are signalled through mem_ready.
interface rv32_multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_5;
    logic             branch_taken;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             addr_src;
    logic             mem_req;
    logic             mem_we;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             illegal_instr;
    logic             bus_error;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] cycles;

    modport master (
        input  opcode, funct3, funct7_5, branch_taken, mem_ready,
        output pc_write, ir_write, addr_src, mem_req, mem_we, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, bus_error,
               instret, cycles
    );

    modport slave (
        output opcode, funct3, funct7_5, branch_taken, mem_ready,
        input  pc_write, ir_write, addr_src, mem_req, mem_we, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, bus_error,
               instret, cycles
    );
endinterface

// File: rtl/rv32_wait_timer.sv
// Counts consecutive stalled memory cycles and flags a timeout on the WAIT_MAX-th one.
// Latency: timeout is combinational from the current count and mem_ready.
// Backpressure: restarts whenever the request completes, drops, or the FSM changes state.
module rv32_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic active,
    input  logic ready,
    input  logic restart,
    output logic timeout
);
    localparam int W = $clog2(WAIT_MAX + 1);

    logic [W-1:0] cnt;

    assign timeout = active && !ready && (cnt == W'(WAIT_MAX - 1));

    // Count stalled cycles of the current request, clearing on any break in the stall.
    always_ff @(posedge CLK) begin
        if (RST || !active || ready || restart) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle RV32I control FSM; optional perf counters built when RV32_CTRL_PERF_EN is defined.
// Latency: R/I/upper/store/JALR 4, load 5, branch/JAL 3 cycles with zero memory wait.
// Backpressure: holds FETCH/MEMRD/MEMWR until mem_ready; traps after WAIT_MAX stalled cycles.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    rv32_multicycle_ctrl_if.master  bus
);
    state_e state;
    state_e next_state;
    ctl_t   ctl_q;
    logic   illegal_q;
    logic   bus_err_q;
    logic   timeout;
    logic   run;

    // ALU control decode of funct3/funct7_5 happens in the datapath.
    logic unused_ir;
    assign unused_ir = ^{bus.funct3, bus.funct7_5};

    assign run = !RST;

    rv32_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .CLK     (CLK),
        .RST     (RST),
        .active  (bus.mem_req),
        .ready   (bus.mem_ready),
        .restart (next_state != state),
        .timeout (timeout)
    );

    // Next-state selection from current state, opcode and memory handshake.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = bus.mem_ready ? S_DECODE : (timeout ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_REG:            next_state = S_EXECR;
                    OP_IMM:            next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: next_state = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = bus.mem_ready ? S_MEMWB : (timeout ? S_TRAP : S_MEMRD);
            S_MEMWR:  next_state = bus.mem_ready ? S_FETCH : (timeout ? S_TRAP : S_MEMWR);
            S_EXECR, S_EXECI, S_UPPER:       next_state = S_ALUWB;
            S_ALUWB, S_MEMWB, S_BRANCH, S_JAL: next_state = S_FETCH;
            S_JALR:   next_state = S_JAL;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_TRAP;
        endcase
    end

    // State register with the matching control word and sticky trap causes registered alongside.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_FETCH;
            ctl_q     <= ctl_for(S_FETCH, 7'd0);
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            ctl_q <= ctl_for(next_state, bus.opcode);
            if (state == S_DECODE && next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Every output is forced low during reset so an aborted instruction cannot write anything.
    assign bus.mem_req       = run && ctl_q.mem_req;
    assign bus.mem_we        = run && ctl_q.mem_we;
    assign bus.addr_src      = run && ctl_q.addr_src;
    assign bus.reg_write     = run && ctl_q.reg_write;
    assign bus.alu_src_a     = run ? ctl_q.alu_src_a  : 2'b00;
    assign bus.alu_src_b     = run ? ctl_q.alu_src_b  : 2'b00;
    assign bus.alu_op        = run ? ctl_q.alu_op     : 2'b00;
    assign bus.result_src    = run ? ctl_q.result_src : 2'b00;
    assign bus.ir_write      = run && (state == S_FETCH) && bus.mem_ready;
    assign bus.pc_write      = run && (ctl_q.pc_write
                                       || ((state == S_FETCH)  && bus.mem_ready)
                                       || ((state == S_BRANCH) && bus.branch_taken));
    assign bus.illegal_instr = run && illegal_q;
    assign bus.bus_error     = run && bus_err_q;

`ifdef RV32_CTRL_PERF_EN
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] instret_q;

    // Cycle and retirement counters; both stop advancing once the core has trapped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else if (state != S_TRAP) begin
            cycles_q <= cycles_q + CNT_W'(1);
            if (state != S_FETCH && next_state == S_FETCH) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign bus.cycles  = cycles_q;
    assign bus.instret = instret_q;
`else
    assign bus.cycles  = '0;
    assign bus.instret = '0;
`endif
endmodule
